mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the CPU-to-Data_RAM access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_access_pkg;

   // Default RAM geometry: 64 KiB of byte-wide storage.
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   // Bytes moved by a 16-bit word access.
   localparam int WORD_BYTES = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } mau_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Sequences CPU byte/word requests onto a byte-wide synchronous Data_RAM.
// Latency (accept edge to rsp_valid): byte wr 2, byte rd 3, word wr 3, word rd 5 cycles.
// Backpressure: req_ready is high only in IDLE; the requester holds req_* until accepted.
//
// Ports: clk, rst (async, active-low); req_valid/req_ready/req_write/req_word/req_addr/req_wdata
//        CPU request; rsp_valid (1-cycle pulse) / rsp_rdata read result; ram_we/ram_addr/
//        ram_wdata drive the RAM, ram_rdata is its registered data_out.
// Build option: define MEM_WORD_EN to enable 16-bit little-endian (two-byte) accesses;
//        without it req_word is ignored and every access is a single byte.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_word,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   mau_state_t state;
   logic       write_q;

   // ram_addr doubles as the latched request address: it is loaded at acceptance
   // and only ever advanced by one for the second byte of a word access.
`ifdef MEM_WORD_EN
   logic              word_q;
   logic              byte_idx;
   logic [DATA_W-1:0] hi_q;      // upper write byte, issued on the second pass
   logic              last_byte;

   assign last_byte = !word_q || (byte_idx == 1'(WORD_BYTES - 1));
`else
   // Word-access inputs have no function in the byte-only build.
   logic unused_word_inputs;
   assign unused_word_inputs = ^{req_word, req_wdata[15:DATA_W]};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         write_q   <= 1'b0;
`ifdef MEM_WORD_EN
         word_q    <= 1'b0;
         byte_idx  <= 1'b0;
         hi_q      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // req_ready is 1 throughout IDLE, so req_valid alone marks acceptance.
               if (req_valid) begin
                  state     <= ISSUE;
                  req_ready <= 1'b0;
                  write_q   <= req_write;
                  ram_we    <= req_write;
                  ram_addr  <= req_addr;
                  ram_wdata <= req_wdata[DATA_W-1:0];
`ifdef MEM_WORD_EN
                  word_q    <= req_word;
                  byte_idx  <= 1'b0;
                  hi_q      <= req_wdata[DATA_W +: DATA_W];
`endif
               end
            end

            ISSUE: begin
               ram_we <= 1'b0;
               if (!write_q) begin
                  state <= CAPTURE;
               end
`ifdef MEM_WORD_EN
               else if (!last_byte) begin
                  // Second byte of a word write: stay in ISSUE for one more strobe.
                  byte_idx  <= 1'b1;
                  ram_addr  <= ram_addr + ADDR_W'(1);
                  ram_wdata <= hi_q;
                  ram_we    <= 1'b1;
               end
`endif
               else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
            end

            CAPTURE: begin
               // RAM data_out for the address presented in ISSUE is valid this cycle.
`ifdef MEM_WORD_EN
               if (byte_idx) rsp_rdata[DATA_W +: DATA_W] <= ram_rdata;
               else          rsp_rdata <= {{(16 - DATA_W){1'b0}}, ram_rdata};
               if (last_byte) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  byte_idx <= 1'b1;
                  ram_addr <= ram_addr + ADDR_W'(1);
                  state    <= ISSUE;
               end
`else
               rsp_rdata <= {{(16 - DATA_W){1'b0}}, ram_rdata};
               state     <= RESP;
               rsp_valid <= 1'b1;
`endif
            end

            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               ram_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-wide Data_RAM.
// Latency: n/a.
// Backpressure: requests are held until req_ready, as a real requester would.
module tb_mem_access_unit;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_word;
   logic [ADDR_W-1:0] req_addr;
   logic [15:0]       req_wdata;
   logic              rsp_valid;
   logic [15:0]       rsp_rdata;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   int checks   = 0;
   int failures = 0;

   // Data_RAM model: synchronous write, data_out registered one cycle after the address.
   logic [DATA_W-1:0] mem [0:65535];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_word  (req_word),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge in IDLE; returns cycles from the acceptance edge
   // to rsp_valid, the number of ram_we cycles and the address of the first write strobe.
   task automatic access(input logic wr, input logic wd, input logic [15:0] a,
                         input logic [15:0] wdat, output int lat, output int we_cnt,
                         output logic [15:0] we_addr);
      check($sformatf("ready_before_%0h", a), 32'(req_ready), 1);
      req_valid = 1'b1;
      req_write = wr;
      req_word  = wd;
      req_addr  = a;
      req_wdata = wdat;
      @(posedge clk);
      #1;
      // Scramble the request bus: the DUT must work from its latched copy.
      req_valid = 1'b0;
      req_write = ~wr;
      req_word  = ~wd;
      req_addr  = ~a;
      req_wdata = ~wdat;
      lat     = 0;
      we_cnt  = 0;
      we_addr = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         lat++;
         if (ram_we) begin
            if (we_cnt == 0) we_addr = ram_addr;
            we_cnt++;
         end
         if (rsp_valid) break;
      end
      @(negedge clk);
      check($sformatf("rsp_one_cycle_%0h", a), 32'(rsp_valid), 0);
   endtask

   logic [15:0] t_addr [3] = '{16'h0000, 16'h0002, 16'h0003};
   logic [7:0]  t_dat  [3] = '{8'hFF, 8'hAA, 8'hF0};

   int          lat;
   int          we_cnt;
   int          acc;
   int          rsp;
   logic [15:0] we_addr;

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_word  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);

      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 0);
      check("rst_ram_we",    32'(ram_we),    0);
      check("rst_ram_addr",  32'(ram_addr),  0);
      check("rst_ram_wdata", 32'(ram_wdata), 0);
      rst = 1'b1;
      @(negedge clk);

      // Byte writes; the upper wdata byte is junk and must not matter.
      for (int i = 0; i < 3; i++) begin
         access(1'b1, 1'b0, t_addr[i], {8'hC3, t_dat[i]}, lat, we_cnt, we_addr);
         check($sformatf("bw%0d_latency", i), lat, 2);
         check($sformatf("bw%0d_we_count", i), we_cnt, 1);
         check($sformatf("bw%0d_we_addr", i), 32'(we_addr), 32'(t_addr[i]));
         check($sformatf("bw%0d_ram", i), 32'(mem[t_addr[i]]), 32'(t_dat[i]));
      end

      // Byte reads back, zero-extended.
      for (int i = 0; i < 3; i++) begin
         access(1'b0, 1'b0, t_addr[i], 16'h0000, lat, we_cnt, we_addr);
         check($sformatf("br%0d_latency", i), lat, 3);
         check($sformatf("br%0d_we_count", i), we_cnt, 0);
         check($sformatf("br%0d_rdata", i), 32'(rsp_rdata), 32'({8'h00, t_dat[i]}));
      end

      // A write leaves the last read result in place.
      access(1'b1, 1'b0, 16'h0005, 16'h0011, lat, we_cnt, we_addr);
      check("rdata_hold_after_write", 32'(rsp_rdata), 'h00F0);
      check("bw5_ram", 32'(mem[16'h0005]), 'h11);

`ifdef MEM_WORD_EN
      access(1'b1, 1'b1, 16'h0010, 16'h1234, lat, we_cnt, we_addr);
      check("ww10_latency", lat, 3);
      check("ww10_we_count", we_cnt, 2);
      check("ww10_we_addr", 32'(we_addr), 'h0010);
      check("ww10_ram_lo", 32'(mem[16'h0010]), 'h34);
      check("ww10_ram_hi", 32'(mem[16'h0011]), 'h12);
      access(1'b0, 1'b1, 16'h0010, 16'h0000, lat, we_cnt, we_addr);
      check("wr10_latency", lat, 5);
      check("wr10_rdata", 32'(rsp_rdata), 'h1234);
      access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, we_cnt, we_addr);
      check("br10_zero_ext", 32'(rsp_rdata), 'h0034);
      access(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, lat, we_cnt, we_addr);
      check("wwffff_ram_lo", 32'(mem[16'hFFFF]), 'hEF);
      check("wwffff_ram_wrap", 32'(mem[16'h0000]), 'hBE);
      access(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, we_cnt, we_addr);
      check("wrffff_rdata", 32'(rsp_rdata), 'hBEEF);
`else
      // req_word has no effect: a "word" request is a single-byte access.
      access(1'b1, 1'b0, 16'h0021, 16'h0077, lat, we_cnt, we_addr);
      access(1'b1, 1'b1, 16'h0020, 16'h1234, lat, we_cnt, we_addr);
      check("ww20_latency", lat, 2);
      check("ww20_we_count", we_cnt, 1);
      check("ww20_ram_lo", 32'(mem[16'h0020]), 'h34);
      check("ww20_ram_next", 32'(mem[16'h0021]), 'h77);
      access(1'b0, 1'b1, 16'h0020, 16'h0000, lat, we_cnt, we_addr);
      check("wr20_latency", lat, 3);
      check("wr20_rdata", 32'(rsp_rdata), 'h0034);
`endif

      // Reset during the write strobe that targets 0x41.
      access(1'b1, 1'b0, 16'h0041, 16'h005A, lat, we_cnt, we_addr);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_word  = 1'b1;
`ifdef MEM_WORD_EN
      req_addr  = 16'h0040;
`else
      req_addr  = 16'h0041;
`endif
      req_wdata = 16'h9966;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`ifdef MEM_WORD_EN
      @(posedge clk);
      #1;
`endif
      check("abort_we_live", 32'(ram_we), 1);
      rst = 1'b0;
      #1;
      check("abort_we_cleared", 32'(ram_we), 0);
      check("abort_ready", 32'(req_ready), 1);
      check("abort_rsp_valid", 32'(rsp_valid), 0);
      check("abort_ram_addr", 32'(ram_addr), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("abort_ram_untouched", 32'(mem[16'h0041]), 'h5A);
`ifdef MEM_WORD_EN
      check("abort_first_byte_kept", 32'(mem[16'h0040]), 'h66);
`endif
      rsp = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) rsp++;
      end
      check("abort_no_rsp", rsp, 0);

      // Requester holds req_valid high: one acceptance per IDLE visit, one response each.
      acc = 0;
      rsp = 0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_word  = 1'b0;
      req_addr  = 16'h0002;
      req_wdata = 16'h0000;
      for (int k = 0; k < 30; k++) begin
         if (req_ready) acc++;
         if (rsp_valid) rsp++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid) rsp++;
         @(negedge clk);
      end
      check("hold_acceptances", acc, 8);
      check("hold_responses", rsp, 8);
      check("hold_rdata", 32'(rsp_rdata), 'h00AA);
      check("hold_ready_end", 32'(req_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
